pll_lock_supervisor: RTL and testbench
======================================

// Module: pll_lock_supervisor
// PURPOSE
//  Controlling end of the PLL rst/lock interface: drives the PLL reset, watches its lock output,
//  retries on lock timeout, re-locks on lock loss. Issues the design-wide reset only once lock is stable.
//  Runs on the free-running 25 MHz board clock that also feeds the PLL clkin1; sits beside the PLL wrapper.
// PARAMETERS
//  RST_PULSE_CYC    25     PLL reset pulse width, clkin1 cycles (1 us at 25 MHz)
//  LOCK_TIMEOUT_CYC 25000  max cycles from pll_rst release to stable lock (1 ms)
//  LOCK_STABLE_CYC  256    consecutive synced-lock-high cycles required before RUN
//  MAX_RETRY        3      lock timeouts tolerated before FAIL (range 1..15)
// PORTS
//  clkin1      in   1  free-running reference clock
//  rst         in   1  asynchronous, active-high reset
//  pll_lock    in   1  PLL lock, asynchronous to clkin1
//  relock_req  in   1  single-cycle request to restart lock sequence
//  pll_rst     out  1  reset to PLL, active-high
//  sys_rst     out  1  downstream reset, active-high; low only in RUN
//  pll_ready   out  1  high only in RUN
//  pll_fail    out  1  high only in FAIL
//  retry_cnt   out  4  lock timeouts since last RUN/relock
//  loss_cnt    out  8  lock-loss events in RUN (only with macro, see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst=1, async): state=RESET, timers=0, retry_cnt=0, pll_rst=1, sys_rst=1, pll_ready=0, pll_fail=0, loss_cnt=0.
//  - pll_lock passes a 2-flop synchronizer (lock_s); all decisions use lock_s (2-cycle latency).
//  - All outputs registered; Moore-decoded from next state, so valid on the first cycle in a state.
//  - RESET: pll_rst=1; tmr counts 0..RST_PULSE_CYC-1, then -> WAIT_LOCK; tmr and to_cnt cleared.
//  - WAIT_LOCK: pll_rst=0, to_cnt++. lock_s=1 -> STABLE (tmr=0).
//    to_cnt==LOCK_TIMEOUT_CYC-1 -> retry_cnt++. If new retry_cnt==MAX_RETRY -> FAIL, else -> RESET.
//  - STABLE: to_cnt keeps running (not cleared); tmr++ while lock_s=1.
//    lock_s=0 -> WAIT_LOCK (tmr=0, to_cnt kept).
//    tmr==LOCK_STABLE_CYC-1 with lock_s=1 -> RUN.
//    Timeout in STABLE is handled as in WAIT_LOCK and takes priority over the RUN transition.
//  - RUN: sys_rst=0, pll_ready=1, retry_cnt cleared on entry.
//    lock_s=0 -> RESET (loss event).
//  - FAIL: pll_rst=1, sys_rst=1, pll_fail=1. Sticky until rst or relock_req.
//  - relock_req: honoured in RUN and FAIL only (ignored elsewhere) -> RESET, retry_cnt=0.
//    If relock_req and lock loss occur in the same RUN cycle: -> RESET, counted as a loss.
//  - sys_rst asserts on the same edge the state leaves RUN, so the PLL is never reset while sys_rst=0.
//  - Counters saturate; to_cnt/tmr widths = $clog2 of the respective parameter.
//  - rst asserted mid-sequence aborts immediately to reset values; there is no partial state retention.
// CONFIGURATION
//  PLL_SUP_LOSS_CNT_EN defined: loss_cnt is an 8-bit saturating count of RUN->RESET transitions caused by lock loss;
//    cleared only by rst, not by relock_req.
//  Not defined: loss_cnt tied to 8'd0, no counter flops.
// STRUCTURE
//  pll_sup_pkg: state enum {RESET, WAIT_LOCK, STABLE, RUN, FAIL}, RETRY_W=4, LOSS_W=8 constants.
//  Sub-module pll_sup_sync2: 2-flop synchronizer, async active-high reset to 0; instanced for pll_lock.
//  Rest (FSM, tmr, to_cnt, retry_cnt, loss_cnt) flat in pll_lock_supervisor.
// TESTING
//  1 Release rst, pll_lock rises 100 cycles after pll_rst falls, held high
//    -> pll_rst high exactly 25 cycles; RUN/pll_ready=1, sys_rst=0 at 100+2+256 cycles after pll_rst release.
//  2 pll_lock never rises
//    -> 3 pll_rst pulses at 25025-cycle spacing, retry_cnt 1,2,3; pll_fail=1 after third timeout; sys_rst stays 1.
//  3 In RUN, drop pll_lock 1 cycle
//    -> 2 cycles later pll_rst=1, sys_rst=1, pll_ready=0 on same edge; loss_cnt=1 with PLL_SUP_LOSS_CNT_EN, else 0.
//  4 pll_lock glitches low every 200 cycles during STABLE
//    -> never reaches RUN; timeout at 25000 cycles after pll_rst release; retry_cnt=1, new pll_rst pulse.
//  5 relock_req in FAIL, then lock good -> RESET, retry_cnt=0, reaches RUN. relock_req in WAIT_LOCK -> ignored.
//  6 rst pulsed mid-STABLE -> all outputs at reset values asynchronously; sequence restarts with 25-cycle pll_rst.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// Shared types and widths for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } state_e;

  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// PLL control/status bundle; master = supervisor side, slave = PLL wrapper / system side.
interface pll_lock_supervisor_if;
  import pll_sup_pkg::*;

  logic               pll_lock;
  logic               relock_req;
  logic               pll_rst;
  logic               sys_rst;
  logic               pll_ready;
  logic               pll_fail;
  logic [RETRY_W-1:0] retry_cnt;
  logic [LOSS_W-1:0]  loss_cnt;

  modport master (
    input  pll_lock, relock_req,
    output pll_rst, sys_rst, pll_ready, pll_fail, retry_cnt, loss_cnt
  );

  modport slave (
    output pll_lock, relock_req,
    input  pll_rst, sys_rst, pll_ready, pll_fail, retry_cnt, loss_cnt
  );

endinterface

// File: rtl/pll_sup_sync2.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module pll_sup_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking (<=) so both stages update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: pulses pll_rst, waits for stable lock with timeout/retry, gates sys_rst.
// Optional lock-loss counter enabled by defining PLL_SUP_LOSS_CNT_EN.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYC    = 25,
  parameter int unsigned LOCK_TIMEOUT_CYC = 25000,
  parameter int unsigned LOCK_STABLE_CYC  = 256,
  parameter int unsigned MAX_RETRY        = 3
) (
  input logic                   clkin1,
  input logic                   rst,
  pll_lock_supervisor_if.master pll_if
);

  localparam int TMR_W = $clog2(max_u(RST_PULSE_CYC, LOCK_STABLE_CYC));
  localparam int TO_W  = $clog2(LOCK_TIMEOUT_CYC);

  localparam logic [TMR_W-1:0]   RST_LAST    = TMR_W'(RST_PULSE_CYC - 1);
  localparam logic [TMR_W-1:0]   STABLE_LAST = TMR_W'(LOCK_STABLE_CYC - 1);
  localparam logic [TO_W-1:0]    TO_LAST     = TO_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d, tmr_inc;
  logic [TO_W-1:0]    to_q, to_d, to_inc;
  logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic               pll_rst_q, sys_rst_q, ready_q, fail_q;
  logic               lock_s;
  logic               timeout;

  pll_sup_sync2 u_lock_sync (
    .clk (clkin1),
    .rst (rst),
    .d_i (pll_if.pll_lock),
    .q_o (lock_s)
  );

  assign tmr_inc   = (tmr_q == '1)   ? tmr_q   : tmr_q + 1'b1;
  assign to_inc    = (to_q == '1)    ? to_q    : to_q + 1'b1;
  assign retry_inc = (retry_q == '1) ? retry_q : retry_q + 1'b1;
  assign timeout   = (to_q == TO_LAST);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    to_d    = to_q;
    retry_d = retry_q;
    case (state_q)
      RESET: begin
        if (tmr_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          tmr_d   = '0;
          to_d    = '0;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      WAIT_LOCK, STABLE: begin
        // The lock-timeout window spans both states; a lock dropout does not restart it.
        to_d = to_inc;
        if (timeout) begin
          retry_d = retry_inc;
          tmr_d   = '0;
          state_d = (retry_inc == RETRY_MAX) ? FAIL : RESET;
        end else if (state_q == WAIT_LOCK) begin
          if (lock_s) begin
            state_d = STABLE;
            tmr_d   = '0;
          end
        end else if (!lock_s) begin
          state_d = WAIT_LOCK;
          tmr_d   = '0;
        end else if (tmr_q == STABLE_LAST) begin
          state_d = RUN;
          retry_d = '0;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      RUN: begin
        if (!lock_s || pll_if.relock_req) begin
          state_d = RESET;
          tmr_d   = '0;
          retry_d = '0;
        end
      end
      FAIL: begin
        if (pll_if.relock_req) begin
          state_d = RESET;
          tmr_d   = '0;
          retry_d = '0;
        end
      end
      default: begin
        state_d = RESET;
        tmr_d   = '0;
      end
    endcase
  end

  // Outputs decode the next state so they are valid on the first cycle of each state.
  always_ff @(posedge clkin1 or posedge rst) begin
    if (rst) begin
      state_q   <= RESET;
      tmr_q     <= '0;
      to_q      <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      to_q      <= to_d;
      retry_q   <= retry_d;
      pll_rst_q <= (state_d == RESET) || (state_d == FAIL);
      sys_rst_q <= (state_d != RUN);
      ready_q   <= (state_d == RUN);
      fail_q    <= (state_d == FAIL);
    end
  end

  assign pll_if.pll_rst   = pll_rst_q;
  assign pll_if.sys_rst   = sys_rst_q;
  assign pll_if.pll_ready = ready_q;
  assign pll_if.pll_fail  = fail_q;
  assign pll_if.retry_cnt = retry_q;

`ifdef PLL_SUP_LOSS_CNT_EN
  logic              loss_evt;
  logic [LOSS_W-1:0] loss_q;

  // A lock loss in RUN counts even when relock_req arrives in the same cycle.
  assign loss_evt = (state_q == RUN) && !lock_s;

  always_ff @(posedge clkin1 or posedge rst) begin
    if (rst) begin
      loss_q <= '0;
    end else if (loss_evt && (loss_q != '1)) begin
      loss_q <= loss_q + 1'b1;
    end
  end

  assign pll_if.loss_cnt = loss_q;
`else
  assign pll_if.loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed self-checking bench for pll_lock_supervisor (shortened lock timeout to keep runtime small).
module tb_pll_lock_supervisor;

  localparam int RST_CYC = 25;
  localparam int TO_CYC  = 2000;
  localparam int STB_CYC = 256;
  localparam int RETRIES = 3;
`ifdef PLL_SUP_LOSS_CNT_EN
  localparam int LOSS_EN = 1;
`else
  localparam int LOSS_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  pll_lock_supervisor_if bus ();

  pll_lock_supervisor #(
    .RST_PULSE_CYC    (RST_CYC),
    .LOCK_TIMEOUT_CYC (TO_CYC),
    .LOCK_STABLE_CYC  (STB_CYC),
    .MAX_RETRY        (RETRIES)
  ) dut (
    .clkin1 (clk),
    .rst    (rst),
    .pll_if (bus)
  );

  always #20 clk = ~clk;

  // Outputs are sampled and inputs driven on the falling edge; step n means "after rising edge n".
  task automatic step(input int k = 1);
    repeat (k) @(negedge clk);
  endtask

  task automatic do_reset(input logic lock_val);
    rst = 1'b1;
    bus.pll_lock = lock_val;
    bus.relock_req = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic wait_pll_rst_fall(input string tag);
    int n = 0;
    while (bus.pll_rst !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (bus.pll_rst !== 1'b0) begin
      errors++;
      $display("FAIL %s_pll_rst_fall got=%b exp=0 (timed out)", tag, bus.pll_rst);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.pll_ready !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    checks++;
    if (bus.pll_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_wait_ready got=%b exp=1 (timed out)", tag, bus.pll_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.pll_lock = 1'b0;
    bus.relock_req = 1'b0;
    step(2);
    checks += 6;
    if (bus.pll_rst !== 1'b1)   begin errors++; $display("FAIL rst_pll_rst got=%b exp=1", bus.pll_rst); end
    if (bus.sys_rst !== 1'b1)   begin errors++; $display("FAIL rst_sys_rst got=%b exp=1", bus.sys_rst); end
    if (bus.pll_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", bus.pll_ready); end
    if (bus.pll_fail !== 1'b0)  begin errors++; $display("FAIL rst_fail got=%b exp=0", bus.pll_fail); end
    if (bus.retry_cnt !== 4'd0) begin errors++; $display("FAIL rst_retry got=%0d exp=0", bus.retry_cnt); end
    if (bus.loss_cnt !== 8'd0)  begin errors++; $display("FAIL rst_loss got=%0d exp=0", bus.loss_cnt); end
    // pll_rst stays high through rising edges 1..24 after release and drops on edge 25.
    rst = 1'b0;
    for (int n = 1; n <= RST_CYC; n++) begin
      step();
      if (n == RST_CYC - 1) begin
        checks++;
        if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL rst_pulse_last got=%b exp=1", bus.pll_rst); end
      end
      if (n == RST_CYC) begin
        checks++;
        if (bus.pll_rst !== 1'b0) begin errors++; $display("FAIL rst_pulse_end got=%b exp=0", bus.pll_rst); end
      end
    end
  endtask

  // Lock driven after edge 99: lock_s high after edge 101, STABLE on 102, RUN on 102+256 = 358.
  task automatic test_lock_up();
    do_reset(1'b0);
    wait_pll_rst_fall("lockup");
    for (int n = 1; n <= 358; n++) begin
      step();
      if (n == 99) bus.pll_lock = 1'b1;
      if (n == 357) begin
        checks += 2;
        if (bus.pll_ready !== 1'b0) begin errors++; $display("FAIL lockup_ready_early got=%b exp=0", bus.pll_ready); end
        if (bus.sys_rst !== 1'b1)   begin errors++; $display("FAIL lockup_sysrst_early got=%b exp=1", bus.sys_rst); end
      end
      if (n == 358) begin
        checks += 3;
        if (bus.pll_ready !== 1'b1) begin errors++; $display("FAIL lockup_ready got=%b exp=1", bus.pll_ready); end
        if (bus.sys_rst !== 1'b0)   begin errors++; $display("FAIL lockup_sysrst got=%b exp=0", bus.sys_rst); end
        if (bus.retry_cnt !== 4'd0) begin errors++; $display("FAIL lockup_retry got=%0d exp=0", bus.retry_cnt); end
      end
    end
  endtask

  // One-cycle lock drop in RUN: seen by the FSM on edge 3, all status flips on that edge.
  task automatic test_lock_loss();
    bus.pll_lock = 1'b0;
    step();
    bus.pll_lock = 1'b1;
    step();
    checks += 2;
    if (bus.pll_rst !== 1'b0)   begin errors++; $display("FAIL loss_pll_rst_early got=%b exp=0", bus.pll_rst); end
    if (bus.pll_ready !== 1'b1) begin errors++; $display("FAIL loss_ready_early got=%b exp=1", bus.pll_ready); end
    step();
    checks += 4;
    if (bus.pll_rst !== 1'b1)   begin errors++; $display("FAIL loss_pll_rst got=%b exp=1", bus.pll_rst); end
    if (bus.sys_rst !== 1'b1)   begin errors++; $display("FAIL loss_sys_rst got=%b exp=1", bus.sys_rst); end
    if (bus.pll_ready !== 1'b0) begin errors++; $display("FAIL loss_ready got=%b exp=0", bus.pll_ready); end
    if (bus.loss_cnt !== 8'(LOSS_EN)) begin errors++; $display("FAIL loss_cnt got=%0d exp=%0d", bus.loss_cnt, LOSS_EN); end
  endtask

  task automatic test_back_to_back();
    wait_ready("b2b_a");
    bus.relock_req = 1'b1;
    step();
    bus.relock_req = 1'b0;
    checks += 3;
    if (bus.pll_rst !== 1'b1)   begin errors++; $display("FAIL b2b_relock_pll_rst got=%b exp=1", bus.pll_rst); end
    if (bus.pll_ready !== 1'b0) begin errors++; $display("FAIL b2b_relock_ready got=%b exp=0", bus.pll_ready); end
    if (bus.loss_cnt !== 8'(LOSS_EN)) begin errors++; $display("FAIL b2b_relock_loss got=%0d exp=%0d", bus.loss_cnt, LOSS_EN); end
    wait_ready("b2b_b");
    // relock_req lands on the same edge the FSM sees the lock drop: still a loss.
    bus.pll_lock = 1'b0;
    step();
    bus.pll_lock = 1'b1;
    step();
    bus.relock_req = 1'b1;
    step();
    bus.relock_req = 1'b0;
    checks += 3;
    if (bus.pll_rst !== 1'b1)   begin errors++; $display("FAIL b2b_both_pll_rst got=%b exp=1", bus.pll_rst); end
    if (bus.pll_ready !== 1'b0) begin errors++; $display("FAIL b2b_both_ready got=%b exp=0", bus.pll_ready); end
    if (bus.loss_cnt !== 8'(2 * LOSS_EN)) begin errors++; $display("FAIL b2b_both_loss got=%0d exp=%0d", bus.loss_cnt, 2 * LOSS_EN); end
  endtask

  // Lock glitches low every 200 cycles: STABLE never lasts 256 cycles, timeout at edge TO_CYC.
  task automatic test_glitch_timeout();
    bit saw_ready = 1'b0;
    do_reset(1'b0);
    wait_pll_rst_fall("glitch");
    for (int n = 1; n <= TO_CYC; n++) begin
      step();
      if (bus.pll_ready === 1'b1) saw_ready = 1'b1;
      if (n >= 10) bus.pll_lock = ((n % 200) != 0);
      if (n == TO_CYC - 1) begin
        checks++;
        if (bus.pll_rst !== 1'b0) begin errors++; $display("FAIL glitch_pre_timeout got=%b exp=0", bus.pll_rst); end
      end
      if (n == TO_CYC) begin
        checks += 3;
        if (bus.pll_rst !== 1'b1)   begin errors++; $display("FAIL glitch_timeout_rst got=%b exp=1", bus.pll_rst); end
        if (bus.retry_cnt !== 4'd1) begin errors++; $display("FAIL glitch_retry got=%0d exp=1", bus.retry_cnt); end
        if (bus.pll_fail !== 1'b0)  begin errors++; $display("FAIL glitch_fail got=%b exp=0", bus.pll_fail); end
      end
    end
    checks++;
    if (saw_ready !== 1'b0) begin errors++; $display("FAIL glitch_reached_run got=%b exp=0", saw_ready); end
  endtask

  // No lock: timeouts on edges TO, 2TO+25, 3TO+50; the third one enters FAIL.
  task automatic test_no_lock_fail();
    bit sys_low = 1'b0;
    do_reset(1'b0);
    wait_pll_rst_fall("nolock");
    for (int n = 1; n <= 3 * TO_CYC + 60; n++) begin
      step();
      if (bus.sys_rst !== 1'b1) sys_low = 1'b1;
      if (n == TO_CYC - 1 || n == TO_CYC + 25 || n == 2 * TO_CYC + 24 || n == 3 * TO_CYC + 49) begin
        checks++;
        if (bus.pll_rst !== 1'b0) begin errors++; $display("FAIL nolock_rst_low_n%0d got=%b exp=0", n, bus.pll_rst); end
      end
      if (n == TO_CYC || n == TO_CYC + 24) begin
        checks += 2;
        if (bus.pll_rst !== 1'b1)   begin errors++; $display("FAIL nolock_rst_hi1_n%0d got=%b exp=1", n, bus.pll_rst); end
        if (bus.retry_cnt !== 4'd1) begin errors++; $display("FAIL nolock_retry1_n%0d got=%0d exp=1", n, bus.retry_cnt); end
      end
      if (n == 2 * TO_CYC + 25) begin
        checks += 3;
        if (bus.pll_rst !== 1'b1)   begin errors++; $display("FAIL nolock_rst_hi2 got=%b exp=1", bus.pll_rst); end
        if (bus.retry_cnt !== 4'd2) begin errors++; $display("FAIL nolock_retry2 got=%0d exp=2", bus.retry_cnt); end
        if (bus.pll_fail !== 1'b0)  begin errors++; $display("FAIL nolock_fail_early got=%b exp=0", bus.pll_fail); end
      end
      if (n == 3 * TO_CYC + 50) begin
        checks += 3;
        if (bus.pll_rst !== 1'b1)   begin errors++; $display("FAIL nolock_rst_hi3 got=%b exp=1", bus.pll_rst); end
        if (bus.retry_cnt !== 4'd3) begin errors++; $display("FAIL nolock_retry3 got=%0d exp=3", bus.retry_cnt); end
        if (bus.pll_fail !== 1'b1)  begin errors++; $display("FAIL nolock_fail got=%b exp=1", bus.pll_fail); end
      end
    end
    checks += 2;
    if (bus.pll_fail !== 1'b1) begin errors++; $display("FAIL nolock_fail_sticky got=%b exp=1", bus.pll_fail); end
    if (sys_low !== 1'b0)      begin errors++; $display("FAIL nolock_sys_rst_dropped got=%b exp=0", sys_low); end
  endtask

  // Starts in FAIL. relock_req -> RESET on edge 1, WAIT_LOCK on 26; WAIT_LOCK relock ignored; RUN on 40+259.
  task automatic test_relock();
    bus.relock_req = 1'b1;
    for (int p = 1; p <= 299; p++) begin
      step();
      bus.relock_req = (p == 30);
      if (p == 40) bus.pll_lock = 1'b1;
      if (p == 1) begin
        checks += 3;
        if (bus.pll_fail !== 1'b0)  begin errors++; $display("FAIL relock_fail got=%b exp=0", bus.pll_fail); end
        if (bus.pll_rst !== 1'b1)   begin errors++; $display("FAIL relock_pll_rst got=%b exp=1", bus.pll_rst); end
        if (bus.retry_cnt !== 4'd0) begin errors++; $display("FAIL relock_retry got=%0d exp=0", bus.retry_cnt); end
      end
      if (p == 25) begin
        checks++;
        if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL relock_pulse_last got=%b exp=1", bus.pll_rst); end
      end
      if (p == 26 || p == 31 || p == 32) begin
        checks++;
        if (bus.pll_rst !== 1'b0) begin errors++; $display("FAIL relock_wait_p%0d got=%b exp=0", p, bus.pll_rst); end
      end
      if (p == 298) begin
        checks++;
        if (bus.pll_ready !== 1'b0) begin errors++; $display("FAIL relock_ready_early got=%b exp=0", bus.pll_ready); end
      end
      if (p == 299) begin
        checks += 2;
        if (bus.pll_ready !== 1'b1) begin errors++; $display("FAIL relock_ready got=%b exp=1", bus.pll_ready); end
        if (bus.sys_rst !== 1'b0)   begin errors++; $display("FAIL relock_sys_rst got=%b exp=0", bus.sys_rst); end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b0);
    wait_pll_rst_fall("arst");
    bus.pll_lock = 1'b1;
    step(100);
    #5 rst = 1'b1;
    #1;
    checks += 5;
    if (bus.pll_rst !== 1'b1)   begin errors++; $display("FAIL arst_pll_rst got=%b exp=1", bus.pll_rst); end
    if (bus.sys_rst !== 1'b1)   begin errors++; $display("FAIL arst_sys_rst got=%b exp=1", bus.sys_rst); end
    if (bus.pll_ready !== 1'b0) begin errors++; $display("FAIL arst_ready got=%b exp=0", bus.pll_ready); end
    if (bus.pll_fail !== 1'b0)  begin errors++; $display("FAIL arst_fail got=%b exp=0", bus.pll_fail); end
    if (bus.loss_cnt !== 8'd0)  begin errors++; $display("FAIL arst_loss got=%0d exp=0", bus.loss_cnt); end
    step();
    rst = 1'b0;
    step(RST_CYC - 1);
    checks++;
    if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL arst_pulse_last got=%b exp=1", bus.pll_rst); end
    step();
    checks++;
    if (bus.pll_rst !== 1'b0) begin errors++; $display("FAIL arst_pulse_end got=%b exp=0", bus.pll_rst); end
  endtask

  initial begin
    bus.pll_lock = 1'b0;
    bus.relock_req = 1'b0;
    test_reset();
    test_lock_up();
    test_lock_loss();
    test_back_to_back();
    test_glitch_timeout();
    test_no_lock_fail();
    test_relock();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
